// File: rtl/match_scorer.sv
// match_scorer: tug-of-war point scorer with a timed win display and best-of match tracking
module match_scorer #(
  parameter int HALF = 3,
  parameter int GAMES_TO_WIN = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int FAVOUR_LOSER = 1,
  parameter int JUMP_STEP = 1,
  localparam int W = 2 * HALF + 1,
  localparam int CW = $clog2(GAMES_TO_WIN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          winrnd,
  input  logic          right,
  input  logic          leds_on,
  input  logic          new_match,
  output logic [W-1:0]  score,
  output logic          game_over,
  output logic [CW-1:0] games_l,
  output logic [CW-1:0] games_r,
  output logic          match_over,
  output logic          match_left
);
  localparam int PW = $clog2(HALF + 1) + 1;
  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {PLAY, HOLD, MATCH} mode_t;
  mode_t mode, mode_n;
  logic signed [PW-1:0] pos, pos_n;
  logic [HCW-1:0] hold_cnt, hold_n;
  logic [CW-1:0] gl_n, gr_n;
  logic win_left, win_left_n, mr, toward, done;
  int p, mag, s, np;
  always_comb begin
    p = int'(pos);
    mag = p < 0 ? -p : p;
    mr = right ~^ leds_on;
    toward = mr ? p < 0 : p > 0;
    s = !leds_on ? JUMP_STEP : (FAVOUR_LOSER != 0 && mag == HALF && toward) ? 2 : 1;
    s = toward && s > mag ? mag : s;
    np = mr ? p + s : p - s;
    done = win_left ? games_l == CW'(GAMES_TO_WIN) : games_r == CW'(GAMES_TO_WIN);
  end
  always_comb begin
    mode_n = mode;
    pos_n = pos;
    win_left_n = win_left;
    hold_n = hold_cnt;
    gl_n = games_l;
    gr_n = games_r;
    if (new_match) begin
      mode_n = PLAY;
      pos_n = '0;
      hold_n = '0;
      gl_n = '0;
      gr_n = '0;
    end else if (mode == PLAY && winrnd) begin
      if (np > HALF || np < -HALF) begin
        mode_n = HOLD;
        hold_n = '0;
        win_left_n = np < 0;
        gl_n = np < 0 ? games_l + CW'(games_l != CW'(GAMES_TO_WIN)) : games_l;
        gr_n = np > 0 ? games_r + CW'(games_r != CW'(GAMES_TO_WIN)) : games_r;
      end else begin
        pos_n = PW'(np);
      end
    end else if (mode == HOLD) begin
      hold_n = hold_cnt + 1'b1;
      if (hold_cnt == HCW'(HOLD_CYCLES - 1)) begin
        mode_n = done ? MATCH : PLAY;
        pos_n = '0;
        hold_n = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= PLAY;
      pos <= '0;
      win_left <= 1'b0;
      hold_cnt <= '0;
      games_l <= '0;
      games_r <= '0;
    end else begin
      mode <= mode_n;
      pos <= pos_n;
      win_left <= win_left_n;
      hold_cnt <= hold_n;
      games_l <= gl_n;
      games_r <= gr_n;
    end
  end
  // Win pattern lights the winner's half only; neutral stays dark.
  always_comb begin
    score = '0;
    for (int i = 0; i < W; i++)
      score[i] = mode == PLAY ? i == HALF - p : win_left ? i > HALF : i < HALF;
  end
  assign game_over = mode != PLAY;
  assign match_over = mode == MATCH;
  assign match_left = match_over & win_left;
endmodule

// File: tb/tb_match_scorer.sv
// tb_match_scorer: table vectors, hand corner sequences and random traffic against a behavioural model
module tb_match_scorer;
  localparam int HALF = 3;
  typedef struct {int mode; int pos; bit wl; int hc; int gl; int gr;} ms_t;
  typedef struct {int fav; int js; int hold; int gtw;} mp_t;
  typedef struct {bit w; bit r; bit l; bit nm; logic [6:0] sc; bit go; int gl; int gr;} vec_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic winrnd = 1'b0, right = 1'b0, leds_on = 1'b0, new_match = 1'b0;
  logic [6:0] score1, score2;
  logic go1, go2, mo1, mo2, ml1, ml2;
  logic [1:0] gl1, gr1;
  logic [0:0] gl2, gr2;
  int n_chk = 0, n_fail = 0;
  ms_t m1, m2;
  mp_t p1 = '{1, 1, 16, 2};
  mp_t p2 = '{0, 2, 3, 1};
  vec_t tbl[16];

  always #5 clk = ~clk;

  match_scorer u1 (
    .clk(clk), .rst_n(rst_n), .winrnd(winrnd), .right(right), .leds_on(leds_on),
    .new_match(new_match), .score(score1), .game_over(go1), .games_l(gl1), .games_r(gr1),
    .match_over(mo1), .match_left(ml1)
  );
  match_scorer #(.HALF(3), .GAMES_TO_WIN(1), .HOLD_CYCLES(3), .FAVOUR_LOSER(0), .JUMP_STEP(2)) u2 (
    .clk(clk), .rst_n(rst_n), .winrnd(winrnd), .right(right), .leds_on(leds_on),
    .new_match(new_match), .score(score2), .game_over(go2), .games_l(gl2), .games_r(gr2),
    .match_over(mo2), .match_left(ml2)
  );

  function automatic ms_t rst_state();
    ms_t z;
    z = '{0, 0, 1'b0, 0, 0, 0};
    return z;
  endfunction

  function automatic ms_t mstep(ms_t m, mp_t p, bit w, bit r, bit l, bit nm);
    ms_t n;
    int dir, s, np;
    n = m;
    if (nm) return rst_state();
    if (m.mode == 0 && w) begin
      dir = (r == l) ? 1 : -1;
      if (!l) s = p.js;
      else if (p.fav != 0 && (m.pos == HALF || m.pos == -HALF) && dir * m.pos < 0) s = 2;
      else s = 1;
      np = m.pos + dir * s;
      if (m.pos * np < 0) np = 0;
      if (np > HALF || np < -HALF) begin
        n.mode = 1;
        n.hc = 0;
        n.wl = np < 0;
        if (np < 0) n.gl = m.gl + 1;
        else n.gr = m.gr + 1;
      end else n.pos = np;
    end else if (m.mode == 1) begin
      n.hc = m.hc + 1;
      if (n.hc == p.hold) begin
        n.hc = 0;
        n.pos = 0;
        n.mode = ((m.wl ? m.gl : m.gr) == p.gtw) ? 2 : 0;
      end
    end
    return n;
  endfunction

  function automatic logic [6:0] escore(ms_t m);
    logic [6:0] one;
    one = 7'b0001000;
    if (m.mode == 0) return m.pos >= 0 ? one >> m.pos : one << (-m.pos);
    return m.wl ? 7'b1110000 : 7'b0000111;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_all(input string t);
    chk({t, " u1.score"}, int'(score1), int'(escore(m1)));
    chk({t, " u1.game_over"}, int'(go1), int'(m1.mode != 0));
    chk({t, " u1.games_l"}, int'(gl1), m1.gl);
    chk({t, " u1.games_r"}, int'(gr1), m1.gr);
    chk({t, " u1.match_over"}, int'(mo1), int'(m1.mode == 2));
    if (m1.mode == 2) chk({t, " u1.match_left"}, int'(ml1), int'(m1.wl));
    chk({t, " u2.score"}, int'(score2), int'(escore(m2)));
    chk({t, " u2.game_over"}, int'(go2), int'(m2.mode != 0));
    chk({t, " u2.games_l"}, int'(gl2), m2.gl);
    chk({t, " u2.games_r"}, int'(gr2), m2.gr);
    chk({t, " u2.match_over"}, int'(mo2), int'(m2.mode == 2));
    if (m2.mode == 2) chk({t, " u2.match_left"}, int'(ml2), int'(m2.wl));
  endtask

  task automatic exp1(input string t, input logic [6:0] sc, input bit go, input int gl, input int gr);
    chk({t, " score"}, int'(score1), int'(sc));
    chk({t, " game_over"}, int'(go1), int'(go));
    chk({t, " games_l"}, int'(gl1), gl);
    chk({t, " games_r"}, int'(gr1), gr);
  endtask

  task automatic cyc(input bit w, input bit r, input bit l, input bit nm);
    winrnd = w;
    right = r;
    leds_on = l;
    new_match = nm;
    @(posedge clk);
    #1;
    m1 = mstep(m1, p1, w, r, l, nm);
    m2 = mstep(m2, p2, w, r, l, nm);
    winrnd = 1'b0;
    new_match = 1'b0;
  endtask

  task automatic do_reset(input string t);
    rst_n = 1'b0;
    #2;
    m1 = rst_state();
    m2 = rst_state();
    check_all(t);
    exp1({t, " hard"}, 7'b0001000, 1'b0, 0, 0);
    chk({t, " match_over"}, int'(mo1), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 7'b0000100, 1'b0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000100, 1'b0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b0001000, 1'b0, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b0010000, 1'b0, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b0100000, 1'b0, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b1000000, 1'b0, 0, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 7'b0010000, 1'b0, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'b0100000, 1'b0, 0, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0010000, 1'b0, 0, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 0, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 7'b0010000, 1'b0, 0, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 0, 0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'b0000100, 1'b0, 0, 0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'b0000010, 1'b0, 0, 0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'b0000001, 1'b0, 0, 0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'b0000111, 1'b1, 0, 1};
    #1;
    do_reset("reset");
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].w, tbl[i].r, tbl[i].l, tbl[i].nm);
      exp1($sformatf("vec%0d", i), tbl[i].sc, tbl[i].go, tbl[i].gl, tbl[i].gr);
      check_all($sformatf("vec%0d", i));
    end
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      exp1($sformatf("hold%0d", i), 7'b0000111, 1'b1, 0, 1);
      check_all("hold");
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp1("hold_end", 7'b0001000, 1'b0, 0, 1);
    check_all("hold_end");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      check_all("g2");
    end
    exp1("g2_win", 7'b0000111, 1'b1, 0, 2);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp1("match", 7'b0000111, 1'b1, 0, 2);
    chk("match match_over", int'(mo1), 1);
    chk("match match_left", int'(ml1), 0);
    check_all("match");
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    exp1("match_frozen", 7'b0000111, 1'b1, 0, 2);
    check_all("match_frozen");
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    exp1("new_match", 7'b0001000, 1'b0, 0, 0);
    chk("new_match match_over", int'(mo1), 0);
    check_all("new_match");
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    exp1("pos2", 7'b0000010, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    exp1("nm_over_winrnd", 7'b0001000, 1'b0, 0, 0);
    check_all("nm_over_winrnd");
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp1("pre_rst_hold", 7'b0000111, 1'b1, 0, 1);
    do_reset("rst_mid_hold");
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp1("post_rst", 7'b0001000, 1'b0, 0, 0);
    check_all("post_rst");
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset("rnd_rst");
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 63) == 0);
      check_all("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
